noc_credit_link: RTL and testbench

- Pipelined, credit-based inter-router link with NUM_VC virtual channels. Sits between one router output port and the neighbouring router input port, on `clk_noc`.
- Receive side: one buffer per VC, refilled through the upstream router's credit loop.
- Transmit side: per-VC credit counters against the downstream buffer, and a round-robin flit arbiter across VCs.
- Forward and credit-return paths are each retimed by NUM_PIPELINE register stages.

---
 rtl/noc_credit_link.sv | 142 ++++++++++++++
 tb/tb_noc_credit_link.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_link.sv
// noc_credit_link: credit-based NoC link with per-VC receive FIFOs, round-robin arbitration and retimed forward/credit paths
module noc_credit_link #(
    parameter int FLIT_WIDTH = 128,
    parameter int DEST_WIDTH = 6,
    parameter int NUM_VC = 2,
    parameter int BUFFER_DEPTH = 4,
    parameter int DOWNSTREAM_CREDITS = 4,
    parameter int NUM_PIPELINE = 0,
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic [VC_W-1:0]       vc_in,
    input  logic                  send_in,
    output logic [NUM_VC-1:0]     credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic [VC_W-1:0]       vc_out,
    output logic                  send_out,
    input  logic [NUM_VC-1:0]     credit_in,
    output logic                  overflow_err,
    output logic                  credit_err
);
    localparam int PW = $clog2(BUFFER_DEPTH);
    localparam int FW = FLIT_WIDTH + DEST_WIDTH + 1;

    logic [FW-1:0]     mem [NUM_VC][BUFFER_DEPTH];
    logic [PW:0]       wr_ptr [NUM_VC];
    logic [PW:0]       rd_ptr [NUM_VC];
    logic [3:0]        cnt [NUM_VC];
    logic [NUM_VC-1:0] full, empty, elig, push, pop, credit_eff;
    logic [VC_W-1:0]   rr_ptr, gvc;
    logic              grant, vc_ok;
    logic [FW-1:0]     fwd_d [NUM_PIPELINE+1];
    logic [VC_W-1:0]   fwd_vc [NUM_PIPELINE+1];
    logic [NUM_PIPELINE:0] fwd_v;

    assign vc_ok = int'(vc_in) < NUM_VC;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v] = wr_ptr[v] == rd_ptr[v];
            full[v]  = (wr_ptr[v] - rd_ptr[v]) == (PW+1)'(BUFFER_DEPTH);
            elig[v]  = !empty[v] && cnt[v] != 4'd0;
            push[v]  = send_in && vc_ok && vc_in == VC_W'(v) && !full[v];
        end
    end

    always_comb begin
        grant = 1'b0;
        gvc   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (!grant && elig[(int'(rr_ptr) + i) % NUM_VC]) begin
                grant = 1'b1;
                gvc   = VC_W'((int'(rr_ptr) + i) % NUM_VC);
            end
        end
        for (int v = 0; v < NUM_VC; v++)
            pop[v] = grant && gvc == VC_W'(v);
    end

    always_ff @(posedge clk_noc) begin
        for (int v = 0; v < NUM_VC; v++)
            if (push[v]) mem[v][wr_ptr[v][PW-1:0]] <= {data_in, dest_in, is_tail_in};
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                cnt[v]    <= 4'(DOWNSTREAM_CREDITS);
            end
            rr_ptr       <= '0;
            credit_out   <= '0;
            overflow_err <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + (PW+1)'(1);
                if (pop[v]) rd_ptr[v] <= rd_ptr[v] + (PW+1)'(1);
                if (credit_eff[v] && !pop[v]) begin
                    if (cnt[v] == 4'(DOWNSTREAM_CREDITS)) credit_err <= 1'b1;
                    else cnt[v] <= cnt[v] + 4'd1;
                end else if (pop[v] && !credit_eff[v]) begin
                    cnt[v] <= cnt[v] - 4'd1;
                end
            end
            credit_out <= pop;
            if (send_in && push == '0) overflow_err <= 1'b1;
            if (grant) rr_ptr <= VC_W'((int'(gvc) + 1) % NUM_VC);
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NUM_PIPELINE; k++) begin
                fwd_d[k]  <= '0;
                fwd_vc[k] <= '0;
            end
            fwd_v <= '0;
        end else begin
            fwd_v[0] <= grant;
            if (grant) begin
                fwd_d[0]  <= mem[gvc][rd_ptr[gvc][PW-1:0]];
                fwd_vc[0] <= gvc;
            end
            for (int k = 1; k <= NUM_PIPELINE; k++) begin
                fwd_v[k] <= fwd_v[k-1];
                if (fwd_v[k-1]) begin
                    fwd_d[k]  <= fwd_d[k-1];
                    fwd_vc[k] <= fwd_vc[k-1];
                end
            end
        end
    end

    assign {data_out, dest_out, is_tail_out} = fwd_d[NUM_PIPELINE];
    assign vc_out   = fwd_vc[NUM_PIPELINE];
    assign send_out = fwd_v[NUM_PIPELINE];

    generate
        if (NUM_PIPELINE == 0) begin : g_crd_direct
            assign credit_eff = credit_in;
        end else begin : g_crd_pipe
            logic [NUM_VC-1:0] crd_q [NUM_PIPELINE];
            always_ff @(posedge clk_noc or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < NUM_PIPELINE; k++) crd_q[k] <= '0;
                end else begin
                    crd_q[0] <= credit_in;
                    for (int k = 1; k < NUM_PIPELINE; k++) crd_q[k] <= crd_q[k-1];
                end
            end
            assign credit_eff = crd_q[NUM_PIPELINE-1];
        end
    endgenerate
endmodule

// File: tb/tb_noc_credit_link.sv
// tb_noc_credit_link: scoreboard bench acting as upstream and downstream router around the link
module tb_noc_credit_link;
    localparam int FW = 32, DW = 6, NV = 2, BD = 4, DC = 3, NP = 1, VW = 1;

    typedef struct packed {
        logic [VW-1:0] vc;
        logic [FW-1:0] d;
        logic [DW-1:0] t;
        logic          tl;
    } flit_t;
    typedef struct {
        int c;
        int v;
    } ev_t;

    logic clk_noc = 1'b0, rst_n = 1'b0;
    logic [FW-1:0] data_in = '0, data_out;
    logic [DW-1:0] dest_in = '0, dest_out;
    logic is_tail_in = 1'b0, is_tail_out, send_in = 1'b0, send_out;
    logic [VW-1:0] vc_in = '0, vc_out;
    logic [NV-1:0] credit_out, credit_in, auto_c = '0, man_c = '0;
    logic overflow_err, credit_err;

    int checks = 0, errors = 0, cyc = 0, idx;
    bit auto_on = 1'b0;
    flit_t exp_q[$];
    flit_t last_f;
    ev_t out_log[$], co_log[$], pend[$];
    int out_cnt[NV], co_cnt[NV], ret_seen[NV], sent_acc[NV];

    assign credit_in = auto_c | man_c;

    noc_credit_link #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_VC(NV), .BUFFER_DEPTH(BD),
        .DOWNSTREAM_CREDITS(DC), .NUM_PIPELINE(NP)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
        .is_tail_in(is_tail_in), .vc_in(vc_in), .send_in(send_in), .credit_out(credit_out),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .vc_out(vc_out),
        .send_out(send_out), .credit_in(credit_in), .overflow_err(overflow_err),
        .credit_err(credit_err)
    );

    always #5 clk_noc = ~clk_noc;
    always @(posedge clk_noc) cyc <= cyc + 1;

    always @(negedge clk_noc) begin
        if (!rst_n) begin
            exp_q.delete();
            out_log.delete();
            co_log.delete();
            pend.delete();
            for (int v = 0; v < NV; v++) begin
                out_cnt[v] = 0;
                co_cnt[v] = 0;
                ret_seen[v] = 0;
            end
        end else begin
            for (int v = 0; v < NV; v++) begin
                ret_seen[v] += int'(credit_in[v]);
                co_cnt[v] += int'(credit_out[v]);
            end
            if (credit_out != '0) co_log.push_back('{cyc, int'(credit_out)});
            if (send_out) begin
                out_log.push_back('{cyc, int'(vc_out)});
                out_cnt[vc_out]++;
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i].vc == vc_out) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL flit_unexpected: got vc=%0d data=%h, no flit outstanding on that vc", vc_out, data_out);
                end else begin
                    if (exp_q[idx] != {vc_out, data_out, dest_out, is_tail_out}) begin
                        errors++;
                        $display("FAIL flit_vc%0d: got %h expected %h", vc_out,
                                 {vc_out, data_out, dest_out, is_tail_out}, exp_q[idx]);
                    end
                    exp_q.delete(idx);
                end
                checks++;
                if (out_cnt[vc_out] - ret_seen[vc_out] > DC) begin
                    errors++;
                    $display("FAIL downstream_overrun vc%0d: got %0d in flight, limit %0d", vc_out,
                             out_cnt[vc_out] - ret_seen[vc_out], DC);
                end
                if (auto_on) pend.push_back('{cyc + int'($urandom_range(0, 4)), int'(vc_out)});
            end
        end
    end

    always @(posedge clk_noc) begin
        #1;
        auto_c = '0;
        for (int v = 0; v < NV; v++)
            for (int i = 0; i < pend.size(); i++)
                if (pend[i].v == v && pend[i].c <= cyc) begin
                    auto_c[v] = 1'b1;
                    pend.delete(i);
                    break;
                end
    end

    function automatic int oc(input int i);
        return i < out_log.size() ? out_log[i].c : -1;
    endfunction
    function automatic int ov(input int i);
        return i < out_log.size() ? out_log[i].v : -1;
    endfunction
    function automatic int cc(input int i);
        return i < co_log.size() ? co_log[i].c : -1;
    endfunction
    function automatic int cv(input int i);
        return i < co_log.size() ? co_log[i].v : -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_noc);
            #1;
        end
    endtask

    task automatic send(input int v, input bit acc);
        flit_t f;
        f.vc = VW'(v);
        f.d = FW'($urandom);
        f.t = DW'($urandom);
        f.tl = 1'($urandom_range(0, 1));
        {vc_in, data_in, dest_in, is_tail_in} = f;
        send_in = 1'b1;
        if (acc) exp_q.push_back(f);
        last_f = f;
        tick();
        send_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        man_c = '0;
        send_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int t0, tc;
        tick(2);
        chk("rst_send_out", send_out, 0);
        chk("rst_credit_out", credit_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_errs", {overflow_err, credit_err}, 0);
        rst_n = 1'b1;
        tick();

        t0 = cyc;
        send(0, 1);
        tick(6);
        chk("single_out_count", out_log.size(), 1);
        chk("single_out_cycle", oc(0), t0 + 3);
        chk("single_out_vc", ov(0), 0);
        chk("single_credit_count", co_log.size(), 1);
        chk("single_credit_cycle", cc(0), t0 + 2);
        chk("single_credit_vec", cv(0), 1);
        chk("single_hold_send", send_out, 0);
        chk("single_hold_data", data_out, last_f.d);

        do_reset();
        repeat (5) send(0, 1);
        tick(8);
        chk("limit_sent", out_cnt[0], DC);
        tc = cyc;
        man_c = 2'b01;
        tick();
        man_c = '0;
        tick(8);
        chk("limit_release_count", out_cnt[0], DC + 1);
        chk("limit_release_cycle", oc(DC), tc + 2 + 2 * NP);
        chk("limit_no_credit_err", credit_err, 0);

        do_reset();
        repeat (5) send(0, 1);
        repeat (5) send(1, 1);
        tick();
        tc = cyc;
        man_c = 2'b11;
        tick(2);
        man_c = '0;
        tick(8);
        chk("rr_total", out_cnt[0] + out_cnt[1], 10);
        chk("rr_first_cycle", oc(6), tc + 4);
        chk("rr_seq", {ov(6), ov(7), ov(8), ov(9)}, {32'd0, 32'd1, 32'd0, 32'd1});
        chk("rr_back_to_back", oc(9) - oc(6), 3);
        send(0, 1);
        send(1, 1);
        tick(6);
        chk("rr_counters_drained", out_cnt[0] + out_cnt[1], 10);

        do_reset();
        tc = cyc;
        man_c = 2'b01;
        tick();
        man_c = '0;
        chk("cerr_before", credit_err, 0);
        tick();
        chk("cerr_after", credit_err, 1);
        repeat (4) send(0, 1);
        tick(8);
        chk("cerr_cnt_saturated", out_cnt[0], DC);

        do_reset();
        repeat (DC + BD) send(1, 1);
        chk("ovf_before", overflow_err, 0);
        send(1, 0);
        chk("ovf_after", overflow_err, 1);
        tick(6);
        chk("ovf_forwarded", out_cnt[1], DC);
        man_c = 2'b10;
        tick(BD);
        man_c = '0;
        tick(10);
        chk("ovf_buffered_drain", out_cnt[1], DC + BD);
        chk("ovf_dropped_gone", exp_q.size(), 0);

        do_reset();
        man_c = 2'b10;
        tick();
        man_c = '0;
        tick(3);
        repeat (5) send(0, 1);
        chk("mid_busy", {send_out, credit_err}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_send", send_out, 0);
        chk("mid_rst_data", {data_out, dest_out, is_tail_out, vc_out}, 0);
        chk("mid_rst_flags", {credit_out, overflow_err, credit_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        t0 = cyc;
        send(1, 1);
        tick(6);
        chk("post_rst_out_count", out_log.size(), 1);
        chk("post_rst_out_cycle", oc(0), t0 + 3);
        chk("post_rst_out_vc", ov(0), 1);
        chk("post_rst_credit_count", co_log.size(), 1);
        chk("post_rst_credit", {cc(0), cv(0)}, {t0 + 2, 32'd2});

        do_reset();
        auto_on = 1'b1;
        for (int v = 0; v < NV; v++) sent_acc[v] = 0;
        for (int n = 0; n < 400; n++) begin
            int v;
            v = $urandom_range(0, NV - 1);
            if ($urandom_range(0, 3) != 0 && BD - (sent_acc[v] - co_cnt[v]) > 0) begin
                send(v, 1);
                sent_acc[v]++;
            end else begin
                tick();
            end
        end
        for (int i = 0; i < 1000 && (exp_q.size() != 0 || pend.size() != 0); i++) tick();
        tick(5);
        chk("rand_drain", exp_q.size(), 0);
        for (int v = 0; v < NV; v++) begin
            chk("rand_credit_out", co_cnt[v], sent_acc[v]);
            chk("rand_credit_back", ret_seen[v], out_cnt[v]);
        end
        chk("rand_errs", {overflow_err, credit_err}, 0);
        auto_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
